// File: rtl/prod_accumulator.sv
// prod_accumulator: sums the unsigned product stream from a registered
// multiplier stage into one dot-product result per operand vector.
// An internal valid/last delay line realigns the operand-side tags with the
// product that leaves the multiplier LAT cycles later. Each finished sum is
// held in a single-entry ready/valid output register that also carries the
// product count and a wrap flag. A sticky flag records overwritten results.
//
// state | meaning
// IDLE  | no vector open; the next aligned product starts a new vector
// ACCUM | vector open; aligned products are added to the running sum
module prod_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LAT    = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_last,
    input  logic [PROD_W-1:0] prod,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum,
    output logic [CNT_W-1:0]  sum_cnt,
    output logic              sum_ovf,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              err_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [LAT-1:0]   dly_v;
    logic [LAT-1:0]   dly_l;
    logic             dv;
    logic             dl;

    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   acc_sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;

    logic             complete;
    logic             sum_valid_nxt;
    logic             overrun_nxt;

    // Tap outputs line up with the product currently on prod.
    assign dv = dly_v[LAT-1];
    assign dl = dly_l[LAT-1];

    assign prod_ext = ACC_W'(prod);
    assign acc_sum  = {1'b0, acc} + {1'b0, prod_ext};
    assign carry    = acc_sum[ACC_W];
    // The count sticks at all-ones rather than wrapping on very long vectors.
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Tag delay line: last is only meaningful alongside valid, so it is
    // masked on entry; clear empties it to discard in-flight products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_v <= '0;
            dly_l <= '0;
        end else if (clear) begin
            dly_v <= '0;
            dly_l <= '0;
        end else begin
            dly_v[0] <= op_valid;
            dly_l[0] <= op_valid & op_last;
            for (int i = 1; i < LAT; i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_l[i] <= dly_l[i-1];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and accumulator update; clear outranks an aligned product.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        complete  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else if (dv) begin
            case (state)
                IDLE: begin
                    acc_nxt = prod_ext;
                    cnt_nxt = CNT_W'(1);
                    ovf_nxt = 1'b0;
                    if (dl) begin
                        complete = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_nxt = acc_sum[ACC_W-1:0];
                    ovf_nxt = ovf | carry;
                    cnt_nxt = cnt_inc;
                    if (dl) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output handshake: a completion always loads (no stall on sum_ready);
    // loading over an unaccepted result is recorded as an overrun.
    always_comb begin
        sum_valid_nxt = sum_valid;
        overrun_nxt   = err_overrun;
        if (clear) begin
            sum_valid_nxt = 1'b0;
        end else if (complete) begin
            sum_valid_nxt = 1'b1;
            if (sum_valid && !sum_ready) begin
                overrun_nxt = 1'b1;
            end
        end else if (sum_valid && sum_ready) begin
            sum_valid_nxt = 1'b0;
        end
    end

    // Running accumulator, product count and wrap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    // Result register: captures the completing beat's totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            sum_cnt <= '0;
            sum_ovf <= 1'b0;
        end else if (complete) begin
            sum     <= acc_nxt;
            sum_cnt <= cnt_nxt;
            sum_ovf <= ovf_nxt;
        end
    end

    // Result valid and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            sum_valid   <= sum_valid_nxt;
            err_overrun <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: models the multiplier stage as a
// LAT-deep product delay and checks results against hand-computed values.
module tb_prod_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int LAT    = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_last = 1'b0;
    logic [PROD_W-1:0] op_prod = '0;
    logic [PROD_W-1:0] prod;
    logic              clear = 1'b0;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  sum_cnt;
    logic              sum_ovf;
    logic              sum_valid;
    logic              sum_ready = 1'b1;
    logic              err_overrun;

    logic [PROD_W-1:0] pp [LAT];

    int checks = 0;
    int failures = 0;

    prod_accumulator #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last),
        .prod(prod), .clear(clear), .sum(sum), .sum_cnt(sum_cnt),
        .sum_ovf(sum_ovf), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Multiplier stage model: product emerges LAT cycles after its operands.
    always @(posedge clk) begin
        pp[0] <= op_prod;
        for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
    end
    assign prod = pp[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [PROD_W-1:0] p);
        op_valid = v;
        op_last  = l;
        op_prod  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        op_last  = 1'b0;
        op_prod  = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] s, input logic [31:0] c,
                           input logic o, input logic v);
        chk({tag, "_sum"}, 32'(sum), s);
        chk({tag, "_cnt"}, 32'(sum_cnt), c);
        chk({tag, "_ovf"}, 32'(sum_ovf), 32'(o));
        chk({tag, "_valid"}, 32'(sum_valid), 32'(v));
    endtask

    initial begin
        // Power-on reset
        #2;
        chk_out("por", 0, 0, 1'b0, 1'b0);
        chk("por_ovr", 32'(err_overrun), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Dot product 10+20+30+40, pulse exactly LAT+1 after the last pair
        sum_ready = 1'b1;
        drive(1, 0, 10);
        drive(1, 0, 20);
        drive(1, 0, 30);
        drive(1, 1, 40);
        idle(LAT - 1);
        chk("dot_early_valid", 32'(sum_valid), 0);
        idle(1);
        chk_out("dot", 100, 4, 1'b0, 1'b1);
        idle(1);
        chk("dot_pulse_drop", 32'(sum_valid), 0);

        // Single-pair vector
        drive(1, 1, 16'hFFFF);
        idle(LAT);
        chk_out("single", 32'h00FFFF, 1, 1'b0, 1'b1);
        idle(1);

        // 300 x 0xFFFF wraps the 24-bit sum and saturates the count
        for (int i = 0; i < 300; i++) drive(1, (i == 299), 16'hFFFF);
        idle(LAT);
        chk_out("ovf", 32'h2BFED4, 255, 1'b1, 1'b1);
        idle(1);

        // Back-to-back completions with sum_ready high
        drive(1, 1, 16'h0011);
        drive(1, 1, 16'h0022);
        idle(LAT - 1);
        chk_out("b2b_first", 32'h11, 1, 1'b0, 1'b1);
        idle(1);
        chk_out("b2b_second", 32'h22, 1, 1'b0, 1'b1);
        idle(1);
        chk("b2b_drop", 32'(sum_valid), 0);
        chk("b2b_no_ovr", 32'(err_overrun), 0);

        // Backpressure: A (2+3) held, then B (3+4) overwrites it
        sum_ready = 1'b0;
        drive(1, 0, 2);
        drive(1, 1, 3);
        idle(LAT);
        chk_out("bp_a", 5, 2, 1'b0, 1'b1);
        idle(2);
        chk("bp_a_hold", 32'(sum), 5);
        chk("bp_a_hold_valid", 32'(sum_valid), 1);
        chk("bp_a_no_ovr", 32'(err_overrun), 0);
        drive(1, 0, 3);
        drive(1, 1, 4);
        idle(LAT);
        chk_out("bp_b", 7, 2, 1'b0, 1'b1);
        chk("bp_ovr", 32'(err_overrun), 1);

        // Flush two in-flight products while a result is still pending
        drive(1, 0, 50);
        drive(1, 1, 60);
        op_valid = 1'b0;
        op_last  = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("flush_drop_valid", 32'(sum_valid), 0);
        chk("flush_keep_ovr", 32'(err_overrun), 1);
        for (int i = 0; i < LAT + 1; i++) begin
            idle(1);
            chk("flush_no_result", 32'(sum_valid), 0);
        end
        sum_ready = 1'b1;
        drive(1, 0, 3);
        drive(1, 1, 4);
        idle(LAT);
        chk_out("post_flush", 7, 2, 1'b0, 1'b1);
        idle(1);
        chk("post_flush_drop", 32'(sum_valid), 0);

        // Asynchronous reset in the middle of an open vector
        sum_ready = 1'b0;
        drive(1, 1, 9);
        idle(LAT);
        chk("pre_rst_valid", 32'(sum_valid), 1);
        drive(1, 0, 100);
        drive(1, 0, 200);
        idle(LAT);
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 1'b0, 1'b0);
        chk("async_rst_ovr", 32'(err_overrun), 0);
        #8;
        rst = 1'b0;
        @(posedge clk);
        #1;
        sum_ready = 1'b1;
        drive(1, 0, 5);
        drive(1, 1, 6);
        idle(LAT);
        chk_out("post_rst", 11, 2, 1'b0, 1'b1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
